video_timing_gen: RTL and testbench

Generates raster timing and a built-in test pattern for the HDMI output path, one pixel per `clk`. Sits directly upstream of the three per-channel TMDS encoders and drives their `VD`, `CD` and `VDE` inputs. The blue encoder takes `CD = {vsync, hsync}`; the red and green encoders take `CD = 2'b00`. All outputs are registered and mutually aligned, so the encoders need no extra delay matching.

---
 rtl/video_timing_pkg.sv | 71 +++++++
 rtl/sync_axis_counter.sv | 42 ++++
 rtl/video_timing_gen.sv | 167 ++++++++++++++++
 tb/tb_video_timing_gen.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared timing presets, colour-bar palette and pattern encodings for video_timing_gen.
// Both presets follow the CEA/VESA timing tables for their modes.
package video_timing_pkg;

    // 640x480 @ 60 Hz preset
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam bit VGA_HS_POL   = 1'b0;
    localparam bit VGA_VS_POL   = 1'b0;

    // 1280x720 @ 60 Hz preset
    localparam int HD720_H_ACTIVE = 1280;
    localparam int HD720_H_FP     = 110;
    localparam int HD720_H_SYNC   = 40;
    localparam int HD720_H_BP     = 220;
    localparam int HD720_V_ACTIVE = 720;
    localparam int HD720_V_FP     = 5;
    localparam int HD720_V_SYNC   = 5;
    localparam int HD720_V_BP     = 20;
    localparam bit HD720_HS_POL   = 1'b1;
    localparam bit HD720_VS_POL   = 1'b1;

    localparam int DEFAULT_CW = 12;

    typedef logic [23:0] rgb_t;

    localparam rgb_t BAR_WHITE   = 24'hFFFFFF;
    localparam rgb_t BAR_YELLOW  = 24'hFFFF00;
    localparam rgb_t BAR_CYAN    = 24'h00FFFF;
    localparam rgb_t BAR_GREEN   = 24'h00FF00;
    localparam rgb_t BAR_MAGENTA = 24'hFF00FF;
    localparam rgb_t BAR_RED     = 24'hFF0000;
    localparam rgb_t BAR_BLUE    = 24'h0000FF;
    localparam rgb_t BAR_BLACK   = 24'h000000;

    localparam int NUM_BARS = 8;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_WHITE = 2'd3
    } pattern_t;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Index NUM_BARS and above means "past the last bar" and maps to black.
    function automatic rgb_t bar_colour(input logic [3:0] idx);
        rgb_t c;
        case (idx)
            4'd0:    c = BAR_WHITE;
            4'd1:    c = BAR_YELLOW;
            4'd2:    c = BAR_CYAN;
            4'd3:    c = BAR_GREEN;
            4'd4:    c = BAR_MAGENTA;
            4'd5:    c = BAR_RED;
            4'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sync_axis_counter.sv
// One raster axis: a wrapping position counter plus active/sync region decode.
// The decode is combinational on the count; the caller registers it.
module sync_axis_counter #(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter bit POL    = 1'b0,
    parameter int CW     = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    output logic [CW-1:0] count,
    output logic          in_active,
    output logic          sync,
    output logic          wrap
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
    localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);
    localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC);

    assign wrap = step && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (step) begin
            count <= wrap ? '0 : count + CW'(1);
        end
    end

    assign in_active = (count < ACT_END);

    // For the vertical axis the count only moves on line wrap, so sync is whole-line.
    assign sync = ((count >= SYNC_START) && (count < SYNC_END)) ? POL : ~POL;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing and test-pattern generator feeding the TMDS encoders.
// Every output is registered from the same (h, v) state, giving one cycle of latency.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit HS_POL   = VGA_HS_POL,
    parameter bit VS_POL   = VGA_VS_POL,
    parameter int CW       = DEFAULT_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    pattern_sel,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          vde,
    output logic [7:0]    red,
    output logic [7:0]    green,
    output logic [7:0]    blue,
    output logic          frame_start
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int BAR_W   = H_ACTIVE / NUM_BARS;

    localparam logic [CW-1:0] BAR_LAST = CW'(BAR_W - 1);
    localparam logic [3:0]    BAR_PAST = 4'(NUM_BARS);

    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic          h_active;
    logic          v_active;
    logic          h_sync_lvl;
    logic          v_sync_lvl;
    logic          h_wrap;
    logic          v_wrap;

    sync_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HS_POL),
        .CW     (CW)
    ) u_h_axis (
        .clk       (clk),
        .rst       (rst),
        .step      (1'b1),
        .count     (h),
        .in_active (h_active),
        .sync      (h_sync_lvl),
        .wrap      (h_wrap)
    );

    sync_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VS_POL),
        .CW     (CW)
    ) u_v_axis (
        .clk       (clk),
        .rst       (rst),
        .step      (h_wrap),
        .count     (v),
        .in_active (v_active),
        .sync      (v_sync_lvl),
        .wrap      (v_wrap)
    );

    // High exactly while (h, v) == (0, 0); both counters land there after reset or a frame wrap.
    logic origin;

    always_ff @(posedge clk) begin
        if (rst) begin
            origin <= 1'b1;
        end else begin
            origin <= v_wrap;
        end
    end

    // Bar position tracked alongside h so no divider is needed.
    logic [CW-1:0] bar_pix;
    logic [3:0]    bar_idx;

    always_ff @(posedge clk) begin
        if (rst || h_wrap) begin
            bar_pix <= '0;
            bar_idx <= '0;
        end else if (bar_pix == BAR_LAST) begin
            bar_pix <= '0;
            if (bar_idx != BAR_PAST) begin
                bar_idx <= bar_idx + 4'd1;
            end
        end else begin
            bar_pix <= bar_pix + CW'(1);
        end
    end

    // Pixel (0,0) already uses the newly sampled selection, so the frame never tears.
    pattern_t pat_q;
    pattern_t pat_cur;

    assign pat_cur = origin ? pattern_t'(pattern_sel) : pat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q <= PAT_BARS;
        end else if (origin) begin
            pat_q <= pat_cur;
        end
    end

    logic de_now;
    rgb_t pix;

    assign de_now = h_active && v_active;

    always_comb begin
        pix = BAR_BLACK;
        if (de_now) begin
            case (pat_cur)
                PAT_BARS:  pix = bar_colour(bar_idx);
                PAT_RAMP:  pix = {3{h[7:0]}};
                PAT_CHECK: pix = (h[3] ^ v[3]) ? BAR_WHITE : BAR_BLACK;
                PAT_WHITE: pix = BAR_WHITE;
                default:   pix = BAR_BLACK;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            vde         <= 1'b0;
            red         <= 8'h00;
            green       <= 8'h00;
            blue        <= 8'h00;
            frame_start <= 1'b0;
        end else begin
            hcount      <= h;
            vcount      <= v;
            hsync       <= h_sync_lvl;
            vsync       <= v_sync_lvl;
            vde         <= de_now;
            red         <= pix[23:16];
            green       <= pix[15:8];
            blue        <= pix[7:0];
            frame_start <= origin;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized bench for video_timing_gen on a reduced raster, checked against a
// pixel-arithmetic reference model through an expected-output queue.
module tb_video_timing_gen;

    localparam int HA = 40;
    localparam int HF = 4;
    localparam int HS = 6;
    localparam int HB = 6;
    localparam int VA = 20;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam bit HP = 1'b0;
    localparam bit VP = 1'b1;
    localparam int CW = 12;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int BW = HA / 8;

    typedef struct packed {
        logic [CW-1:0] hc;
        logic [CW-1:0] vc;
        logic          hs;
        logic          vs;
        logic          de;
        logic [23:0]   rgb;
        logic          fs;
    } out_t;

    logic          clk;
    logic          rst;
    logic [1:0]    pattern_sel;
    logic [CW-1:0] hcount;
    logic [CW-1:0] vcount;
    logic          hsync;
    logic          vsync;
    logic          vde;
    logic [7:0]    red;
    logic [7:0]    green;
    logic [7:0]    blue;
    logic          frame_start;

    video_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .HS_POL   (HP), .VS_POL (VP), .CW (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pattern_sel (pattern_sel),
        .hcount      (hcount),
        .vcount      (vcount),
        .hsync       (hsync),
        .vsync       (vsync),
        .vde         (vde),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .frame_start (frame_start)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // scoreboard state
    out_t exp_q[$];
    bit   rst_q[$];
    int   total = 0;
    int   bad   = 0;

    // reference model state
    int mh = 0;
    int mv = 0;
    int mp = 0;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    function automatic out_t model_pixel(input int x, input int y, input int pat);
        out_t o;
        int   b;
        o.hc  = CW'(x);
        o.vc  = CW'(y);
        o.de  = (x < HA) && (y < VA);
        o.hs  = (x >= HA + HF && x < HA + HF + HS) ? HP : !HP;
        o.vs  = (y >= VA + VF && y < VA + VF + VS) ? VP : !VP;
        o.fs  = (x == 0) && (y == 0);
        o.rgb = 24'h0;
        if (o.de) begin
            case (pat)
                0: begin
                    b = x / BW;
                    o.rgb = (b < 8) ? bars[b] : 24'h0;
                end
                1: o.rgb = {3{8'(x)}};
                2: o.rgb = (((x >> 3) ^ (y >> 3)) & 1) != 0 ? 24'hFFFFFF : 24'h0;
                default: o.rgb = 24'hFFFFFF;
            endcase
        end
        return o;
    endfunction

    task automatic model_step(input bit r, input int s);
        out_t o;
        int   pat;
        if (r) begin
            o = '0;
            o.hs = !HP;
            o.vs = !VP;
            mh = 0;
            mv = 0;
            mp = 0;
        end else begin
            if (mh == 0 && mv == 0) mp = s;
            pat = mp;
            o = model_pixel(mh, mv, pat);
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv++;
                if (mv == VT) mv = 0;
            end
        end
        exp_q.push_back(o);
        rst_q.push_back(r);
    endtask

    // driver tasks
    task automatic cycle(input bit r, input logic [1:0] s);
        rst = r;
        pattern_sel = s;
        @(posedge clk);
        model_step(r, int'(s));
        #1;
    endtask

    logic [1:0] cur_sel;

    task automatic run_random(input int n, input int change_odds);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(change_odds - 1, 0) == 0) cur_sel = 2'($urandom_range(3, 0));
            cycle(1'b0, cur_sel);
        end
    endtask

    // monitor: pop one expected output per cycle and compare
    int per_cnt = 0;
    int de_cnt  = 0;
    bit armed   = 0;

    always @(negedge clk) begin
        out_t obs;
        out_t exp_o;
        bit   was_rst;
        if (exp_q.size() > 0) begin
            exp_o   = exp_q.pop_front();
            was_rst = rst_q.pop_front();
            obs.hc  = hcount;
            obs.vc  = vcount;
            obs.hs  = hsync;
            obs.vs  = vsync;
            obs.de  = vde;
            obs.rgb = {red, green, blue};
            obs.fs  = frame_start;
            total++;
            if (obs !== exp_o) begin
                bad++;
                $display("FAIL pixel%s t=%0t got hc=%0d vc=%0d hs=%b vs=%b de=%b rgb=%h fs=%b exp hc=%0d vc=%0d hs=%b vs=%b de=%b rgb=%h fs=%b",
                         was_rst ? "_reset" : "", $time,
                         obs.hc, obs.vc, obs.hs, obs.vs, obs.de, obs.rgb, obs.fs,
                         exp_o.hc, exp_o.vc, exp_o.hs, exp_o.vs, exp_o.de, exp_o.rgb, exp_o.fs);
            end
            if (was_rst) begin
                armed = 0;
            end else begin
                if (frame_start === 1'b1) begin
                    if (armed) begin
                        total++;
                        if (per_cnt != HT * VT) begin
                            bad++;
                            $display("FAIL frame_period got=%0d exp=%0d", per_cnt, HT * VT);
                        end
                        total++;
                        if (de_cnt != HA * VA) begin
                            bad++;
                            $display("FAIL vde_per_frame got=%0d exp=%0d", de_cnt, HA * VA);
                        end
                    end
                    armed   = 1;
                    per_cnt = 0;
                    de_cnt  = 0;
                end
                per_cnt++;
                if (vde === 1'b1) de_cnt++;
            end
        end
    end

    // stimulus and final report
    initial begin
        rst = 1'b1;
        pattern_sel = 2'd0;
        cur_sel = 2'd0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'd0);

        // colour bars, then switch to checkerboard mid-frame
        while (!(mh == 30 && mv == 10)) cycle(1'b0, 2'd0);
        cur_sel = 2'd2;
        run_random(HT * VT + 200, 1_000_000);

        // random pattern churn across frames
        run_random(2 * HT * VT, 150);

        // reset pulse at a random point mid-frame
        run_random($urandom_range(1400, 100), 150);
        for (int i = 0; i < int'($urandom_range(3, 1)); i++) cycle(1'b1, cur_sel);
        run_random(2 * HT * VT + 100, 200);

        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
